adc_scan_ctrl: RTL and testbench
================================

// Module: adc_scan_ctrl
// PURPOSE
//  Multi-channel sequencer for an external EOC/OE-style SAR ADC (0809 class); successor to the single-channel start/EOC/OE FSM.
//  Scans enabled channels: drives mux address and ALE, pulses START, waits on EOC, strobes OE and captures data.
//  Returns each sample on a valid/ready stream to the PID datapath.
//  Adds EOC timeout recovery, continuous/single-pass modes and output backpressure.
// PARAMETERS
//  NCH      8     number of ADC mux channels (2..16)
//  CH_W     3     channel address width, >= clog2(NCH)
//  DW       8     ADC data width
//  START_W  2     START high time, clk cycles (>=1)
//  OE_W     2     OE high time, clk cycles (>=1); data captured on last OE cycle
//  TO_CYC   1023  EOC wait timeout, clk cycles, covers WAIT_LO+WAIT_HI together
// PORTS
//  clk          in   1     clock
//  rstn         in   1     reset rstn, asynchronous, active-low
//  en           in   1     run enable (level); low = synchronous abort to IDLE
//  cont         in   1     1 = scan continuously; 0 = one pass, re-arm needs en low then high
//  ch_mask      in   NCH   channel enable mask, sampled only in IDLE/NEXT
//  eoc          in   1     ADC end-of-conversion (already synchronised upstream)
//  adc_d        in   DW    ADC data bus
//  ale          out  1     address latch enable
//  start        out  1     conversion start
//  oe           out  1     ADC output enable
//  ch_addr      out  CH_W  ADC mux address
//  smp_valid    out  1     sample valid
//  smp_ready    in   1     sample consumer ready
//  smp_data     out  DW    captured sample
//  smp_ch       out  CH_W  channel of smp_data
//  to_err       out  1     one-cycle pulse on EOC timeout
//  to_sticky    out  1     set by to_err, cleared while en=0
//  busy         out  1     FSM not in IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state IDLE, current channel = NCH-1 (so first pick searches from ch 0).
//  - States: IDLE, SEL, START, WAIT_LO, WAIT_HI, RD, OUT, NEXT.
//  - IDLE: en=1, armed and ch_mask!=0 -> pick lowest enabled channel, go SEL. mask=0 -> stay IDLE.
//  - SEL: 1 cycle; ale=1, ch_addr=channel.
//  - START: start=1 for START_W cycles; ch_addr held.
//  - WAIT_LO: wait eoc=0 (conversion begun) -> WAIT_HI.
//  - WAIT_HI: wait eoc=1 (conversion done) -> RD.
//  - Timeout counter clears on START exit and counts in WAIT_LO/WAIT_HI.
//    Reaching TO_CYC: to_err pulse, to_sticky=1, no sample emitted, go NEXT.
//  - RD: oe=1 for OE_W cycles; adc_d captured into smp_data/smp_ch on the last RD cycle.
//  - OUT: smp_valid=1, data stable until smp_valid&smp_ready; the handshake cycle goes to NEXT.
//  - Latency: adc_d capture -> smp_valid is 1 cycle. Minimum en->first smp_valid is 1+1+START_W+1+1+OE_W cycles.
//  - NEXT (1 cycle): search next enabled channel above current, wrapping NCH-1 -> 0.
//    Wrap past highest enabled channel ends the pass: cont=1 -> SEL; cont=0 -> IDLE and disarm.
//    Mask is re-read here, so mask changes take effect on the next channel.
//  - en=0 in any state: next edge -> IDLE with ale/start/oe/smp_valid = 0; pending sample dropped; re-armed.
//    Also clears to_sticky.
//  - Simultaneous to_err and en=0: abort wins, to_err not pulsed.
//  - rstn low mid-conversion: immediate return to reset values; the ADC is left to finish on its own.
// TESTING
//  1. NCH=8, mask=8'h05, cont=0, eoc model 5 cyc: two samples, ch 2 then ch 0? no, ch0 then ch2 -> busy=0, no third sample.
//  2. cont=1, mask=8'h81, smp_ready=1: sample order 0,7,0,7...; ch_addr at each ale matches.
//  3. smp_ready=0 for 20 cycles in OUT: smp_valid, smp_data, smp_ch stable; no new start until handshake.
//  4. eoc stuck 1, TO_CYC=15: to_err pulses 15 cycles after WAIT_LO entry; to_sticky=1; next channel proceeds; en=0 clears sticky.
//  5. en dropped during RD: next cycle oe=0, state IDLE, no smp_valid; en=1 restarts from lowest enabled channel.
//  6. mask=0 with en=1: busy stays 0, no ale/start. Async rstn mid-WAIT_HI: all outputs 0 immediately.

Source files
------------

// File: rtl/adc_scan_if.sv
// Sample stream from the ADC scan sequencer to the PID datapath.
// The master holds data and channel stable while valid is high and ready is low.
interface adc_scan_if #(
    parameter int DW   = 8,
    parameter int CH_W = 3
) ();
    logic            smp_valid;
    logic            smp_ready;
    logic [DW-1:0]   smp_data;
    logic [CH_W-1:0] smp_ch;

    modport master (
        output smp_valid,
        output smp_data,
        output smp_ch,
        input  smp_ready
    );

    modport slave (
        input  smp_valid,
        input  smp_data,
        input  smp_ch,
        output smp_ready
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Multi-channel scan sequencer for an 0809-class SAR ADC with START/EOC/OE handshake.
// Each converted channel is returned on a valid/ready stream; a stuck EOC is recovered by timeout.
module adc_scan_ctrl #(
    parameter int NCH     = 8,
    parameter int CH_W    = 3,
    parameter int DW      = 8,
    parameter int START_W = 2,
    parameter int OE_W    = 2,
    parameter int TO_CYC  = 1023
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en_i,
    input  logic            cont_i,
    input  logic [NCH-1:0]  ch_mask_i,
    input  logic            eoc_i,
    input  logic [DW-1:0]   adc_d_i,
    output logic            ale_o,
    output logic            start_o,
    output logic            oe_o,
    output logic [CH_W-1:0] ch_addr_o,
    output logic            to_err_o,
    output logic            to_sticky_o,
    output logic            busy_o,
    adc_scan_if.master      smp
);

    localparam int PH_MAX = (START_W > OE_W) ? START_W : OE_W;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEL     = 3'd1,
        S_START   = 3'd2,
        S_WAIT_LO = 3'd3,
        S_WAIT_HI = 3'd4,
        S_RD      = 3'd5,
        S_OUT     = 3'd6,
        S_NEXT    = 3'd7
    } state_t;

    state_t          state_q;
    logic [CH_W-1:0] ch_q;
    logic            armed_q;
    logic [PH_W-1:0] ph_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            ale_q;
    logic            start_q;
    logic            oe_q;
    logic [CH_W-1:0] ch_addr_q;
    logic            valid_q;
    logic [DW-1:0]   data_q;
    logic [CH_W-1:0] smp_ch_q;
    logic            to_err_q;
    logic            sticky_q;
    logic            busy_q;

    logic [CH_W-1:0] low_ch_s;
    logic [CH_W-1:0] above_ch_s;
    logic            above_found_s;
    logic            take_s;
    logic            to_hit_s;

    // Channel search: lowest enabled channel, and lowest enabled channel above the current one
    always_comb begin
        low_ch_s      = '0;
        above_ch_s    = '0;
        above_found_s = 1'b0;
        take_s        = 1'b0;
        for (int j = NCH - 1; j >= 0; j--) begin
            low_ch_s      = ch_mask_i[j] ? CH_W'(j) : low_ch_s;
            take_s        = ch_mask_i[j] && (CH_W'(j) > ch_q);
            above_ch_s    = take_s ? CH_W'(j) : above_ch_s;
            above_found_s = above_found_s | take_s;
        end
        to_hit_s = (to_cnt_q == TO_W'(TO_CYC - 1));
    end

    // Scan FSM with all ADC-side and stream-side outputs registered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            ch_q      <= CH_W'(NCH - 1);
            armed_q   <= 1'b1;
            ph_q      <= '0;
            to_cnt_q  <= '0;
            ale_q     <= 1'b0;
            start_q   <= 1'b0;
            oe_q      <= 1'b0;
            ch_addr_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            smp_ch_q  <= '0;
            to_err_q  <= 1'b0;
            sticky_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else if (!en_i) begin
            // Abort beats a coincident timeout; the pending sample is dropped and the scan re-armed.
            state_q  <= S_IDLE;
            armed_q  <= 1'b1;
            ale_q    <= 1'b0;
            start_q  <= 1'b0;
            oe_q     <= 1'b0;
            valid_q  <= 1'b0;
            to_err_q <= 1'b0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            to_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (armed_q && (ch_mask_i != '0)) begin
                        ch_q      <= low_ch_s;
                        ch_addr_q <= low_ch_s;
                        ale_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_SEL;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_SEL: begin
                    ale_q   <= 1'b0;
                    start_q <= 1'b1;
                    ph_q    <= '0;
                    state_q <= S_START;
                end
                S_START: begin
                    if (ph_q == PH_W'(START_W - 1)) begin
                        start_q  <= 1'b0;
                        to_cnt_q <= '0;
                        state_q  <= S_WAIT_LO;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                S_WAIT_LO, S_WAIT_HI: begin
                    if (to_hit_s) begin
                        to_err_q <= 1'b1;
                        sticky_q <= 1'b1;
                        state_q  <= S_NEXT;
                    end else if ((state_q == S_WAIT_LO) && !eoc_i) begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        state_q  <= S_WAIT_HI;
                    end else if ((state_q == S_WAIT_HI) && eoc_i) begin
                        oe_q    <= 1'b1;
                        ph_q    <= '0;
                        state_q <= S_RD;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_RD: begin
                    if (ph_q == PH_W'(OE_W - 1)) begin
                        oe_q     <= 1'b0;
                        data_q   <= adc_d_i;
                        smp_ch_q <= ch_q;
                        valid_q  <= 1'b1;
                        state_q  <= S_OUT;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (smp.smp_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_NEXT;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    // Wrapping past the highest enabled channel closes the pass.
                    if (above_found_s) begin
                        ch_q      <= above_ch_s;
                        ch_addr_q <= above_ch_s;
                        ale_q     <= 1'b1;
                        state_q   <= S_SEL;
                    end else if ((ch_mask_i != '0) && cont_i) begin
                        ch_q      <= low_ch_s;
                        ch_addr_q <= low_ch_s;
                        ale_q     <= 1'b1;
                        state_q   <= S_SEL;
                    end else begin
                        armed_q <= cont_i;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    ale_q   <= 1'b0;
                    start_q <= 1'b0;
                    oe_q    <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ale_o         = ale_q;
    assign start_o       = start_q;
    assign oe_o          = oe_q;
    assign ch_addr_o     = ch_addr_q;
    assign to_err_o      = to_err_q;
    assign to_sticky_o   = sticky_q;
    assign busy_o        = busy_q;
    assign smp.smp_valid = valid_q;
    assign smp.smp_data  = data_q;
    assign smp.smp_ch    = smp_ch_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl: an ADC model answers START with EOC after a fixed delay
// and drives data 0xA0|channel; expected samples are queued and checked by a stream monitor.
module tb_adc_scan_ctrl;
    localparam int NCH  = 8;
    localparam int CH_W = 3;
    localparam int DW   = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en_i;
    logic            cont_i;
    logic [NCH-1:0]  ch_mask_i;
    logic            eoc_i = 1'b1;
    logic [DW-1:0]   adc_d_i = 8'h00;
    logic            ale_o, start_o, oe_o, to_err_o, to_sticky_o, busy_o;
    logic [CH_W-1:0] ch_addr_o;

    adc_scan_if #(.DW(DW), .CH_W(CH_W)) smp_if ();

    adc_scan_ctrl #(
        .NCH(NCH), .CH_W(CH_W), .DW(DW), .START_W(2), .OE_W(2), .TO_CYC(15)
    ) dut (
        .clk(clk), .rstn(rstn), .en_i(en_i), .cont_i(cont_i), .ch_mask_i(ch_mask_i),
        .eoc_i(eoc_i), .adc_d_i(adc_d_i), .ale_o(ale_o), .start_o(start_o), .oe_o(oe_o),
        .ch_addr_o(ch_addr_o), .to_err_o(to_err_o), .to_sticky_o(to_sticky_o),
        .busy_o(busy_o), .smp(smp_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_smp  = 0;
    logic [CH_W+DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [CH_W-1:0] ch);
        logic [DW-1:0] d;
        d = 8'hA0 | {5'd0, ch};
        exp_q.push_back({ch, d});
    endtask

    // ADC model: latch address on ALE, EOC low for 5 cycles after START ends
    logic [2:0]      cnv_cnt = 3'd0;
    logic [CH_W-1:0] lat_ch = 3'd0;
    logic            stuck;
    always @(negedge clk) begin
        if (ale_o) lat_ch = ch_addr_o;
        if (start_o) begin
            cnv_cnt = 3'd5;
            eoc_i   = 1'b1;
        end else if (cnv_cnt != 3'd0) begin
            cnv_cnt = cnv_cnt - 3'd1;
            eoc_i   = stuck;
        end else begin
            eoc_i = 1'b1;
        end
        adc_d_i = 8'hA0 | {5'd0, lat_ch};
    end

    // Stream monitor: every accepted sample is popped from the scoreboard
    always begin
        @(negedge clk);
        #1;
        if (rstn && smp_if.smp_valid && smp_if.smp_ready) begin
            n_smp++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected got ch %0d data %0h expected no sample",
                         smp_if.smp_ch, smp_if.smp_data);
            end else begin
                chk("sb_sample", {21'd0, smp_if.smp_ch, smp_if.smp_data}, {21'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_busy_done(input string name);
        int k;
        k = 0;
        while (!busy_o && k < 20) begin @(negedge clk); k++; end
        chk({name, "_busy_rise"}, busy_o, 1);
        k = 0;
        while (busy_o && k < 400) begin @(negedge clk); k++; end
        chk({name, "_busy_fall"}, busy_o, 0);
    endtask

    logic [31:0] outs;
    assign outs = {ale_o, start_o, oe_o, ch_addr_o, smp_if.smp_valid, smp_if.smp_data,
                   smp_if.smp_ch, to_err_o, to_sticky_o, busy_o};

    initial begin
        int k;
        int base;
        rstn = 1'b0; en_i = 1'b0; cont_i = 1'b0; ch_mask_i = 8'h00; stuck = 1'b0;
        smp_if.smp_ready = 1'b1;
        #22;
        chk("reset_outputs", outs, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc(2);

        // single pass over channels 0 and 2
        ch_mask_i = 8'h05; cont_i = 1'b0;
        push(3'd0); push(3'd2);
        base = n_smp;
        en_i = 1'b1;
        wait_busy_done("t1");
        cyc(30);
        chk("t1_busy_idle", busy_o, 0);
        chk("t1_count", n_smp - base, 2);
        en_i = 1'b0;
        cyc(2);

        // continuous scan of channels 0 and 7
        ch_mask_i = 8'h81; cont_i = 1'b1;
        for (int i = 0; i < 3; i++) begin push(3'd0); push(3'd7); end
        base = n_smp;
        en_i = 1'b1;
        k = 0;
        while ((n_smp - base) < 6 && k < 600) begin @(negedge clk); k++; end
        chk("t2_count", n_smp - base, 6);
        en_i = 1'b0;
        cyc(3);
        chk("t2_abort_idle", busy_o, 0);

        // backpressure: sample must stay frozen while ready is low
        ch_mask_i = 8'h02; cont_i = 1'b0; smp_if.smp_ready = 1'b0;
        push(3'd1);
        en_i = 1'b1;
        k = 0;
        while (!smp_if.smp_valid && k < 100) begin @(negedge clk); k++; end
        for (int i = 0; i < 20; i++) begin
            chk("t3_hold", {start_o, ale_o, smp_if.smp_valid, smp_if.smp_data, smp_if.smp_ch},
                {1'b0, 1'b0, 1'b1, 8'hA1, 3'd1});
            @(negedge clk);
        end
        smp_if.smp_ready = 1'b1;
        wait_busy_done("t3");
        en_i = 1'b0;
        cyc(2);

        // EOC stuck high: timeout on ch0, ch2 then converts normally
        ch_mask_i = 8'h05; stuck = 1'b1;
        push(3'd2);
        en_i = 1'b1;
        k = 0;
        while (!start_o && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (start_o && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (!to_err_o && k < 40) begin @(negedge clk); k++; end
        chk("t4_to_delay", k, 15);
        chk("t4_sticky_set", to_sticky_o, 1);
        stuck = 1'b0;
        @(negedge clk);
        chk("t4_to_pulse", to_err_o, 0);
        wait_busy_done("t4");
        chk("t4_sticky_hold", to_sticky_o, 1);
        en_i = 1'b0;
        @(negedge clk);
        chk("t4_sticky_clear", to_sticky_o, 0);
        cyc(2);

        // abort during RD, then restart from the lowest enabled channel
        ch_mask_i = 8'h0A;
        en_i = 1'b1;
        k = 0;
        while (!oe_o && k < 100) begin @(negedge clk); k++; end
        chk("t5_oe_seen", oe_o, 1);
        en_i = 1'b0;
        @(negedge clk);
        chk("t5_abort", {oe_o, busy_o, smp_if.smp_valid}, 3'b000);
        cyc(10);
        push(3'd1); push(3'd3);
        en_i = 1'b1;
        wait_busy_done("t5");
        en_i = 1'b0;
        cyc(2);

        // empty mask keeps the sequencer idle
        ch_mask_i = 8'h00; en_i = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            k = k | {29'd0, busy_o, ale_o, start_o};
            @(negedge clk);
        end
        chk("t6_mask0_idle", k, 0);

        // asynchronous reset while waiting for EOC high
        ch_mask_i = 8'h02;
        k = 0;
        while (!start_o && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (start_o && k < 20) begin @(negedge clk); k++; end
        cyc(3);
        chk("t6_busy_before_rst", {busy_o, ch_addr_o}, {1'b1, 3'd1});
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_reset", outs, 32'd0);
        en_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cyc(3);

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
